// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit beside the execute-stage ALU.
// Shift-add multiply and restoring divide on magnitudes; sign applied at completion.
module multdiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    counter;
   logic [WIDTH-1:0] acc_hi;   // product high word / partial remainder
   logic [WIDTH-1:0] acc_lo;   // multiplier / dividend shifting into quotient
   logic [WIDTH-1:0] opb;      // multiplicand / divisor magnitude
   logic             neg;
   logic             is_div;

   logic               start;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mult_sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH-1:0]   rem_diff;
   logic               rem_ge;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   quo_s;
   logic [WIDTH-1:0]   fin_result;
   logic               fin_exc;

   assign start = ctrl_MULT | ctrl_DIV;

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state: a start in any state (re)launches, MULT taking priority
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = IDLE;
         MULT:    if (counter == LAST) state_nxt = DONE;
         DIV:     if (counter == LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (ctrl_MULT)     state_nxt = MULT;
      else if (ctrl_DIV) state_nxt = DIV;
   end

   // Iteration and completion arithmetic
   always_comb begin
      mag_a      = data_operandA[WIDTH-1] ? WIDTH'(-data_operandA) : data_operandA;
      mag_b      = data_operandB[WIDTH-1] ? WIDTH'(-data_operandB) : data_operandB;
      mult_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : (WIDTH+1)'(0));
      rem_sh     = {acc_hi, acc_lo[WIDTH-1]};
      rem_ge     = rem_sh >= {1'b0, opb};
      rem_diff   = rem_sh[WIDTH-1:0] - opb;
      prod_s     = neg ? (2*WIDTH)'(-{acc_hi, acc_lo}) : {acc_hi, acc_lo};
      quo_s      = neg ? WIDTH'(-acc_lo) : acc_lo;
      fin_result = prod_s[WIDTH-1:0];
      fin_exc    = prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}};
      if (is_div) begin
         if (opb == '0) begin
            fin_result = '0;
            fin_exc    = 1'b1;
         end else begin
            fin_result = quo_s;
            // Only MIN / -1 yields an unnegated magnitude of 2^(WIDTH-1)
            fin_exc    = !neg && acc_lo[WIDTH-1];
         end
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         counter        <= '0;
         acc_hi         <= '0;
         acc_lo         <= '0;
         opb            <= '0;
         neg            <= 1'b0;
         is_div         <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
         busy           <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         busy           <= state_nxt != IDLE;
         if (state == DONE) begin
            data_result    <= fin_result;
            data_exception <= fin_exc;
            data_resultRDY <= 1'b1;
         end
         if (start) begin
            counter <= '0;
            acc_hi  <= '0;
            acc_lo  <= mag_a;
            opb     <= mag_b;
            neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            is_div  <= !ctrl_MULT;
         end else if (state == MULT) begin
            counter <= counter + CW'(1);
            acc_hi  <= mult_sum[WIDTH:1];
            acc_lo  <= {mult_sum[0], acc_lo[WIDTH-1:1]};
         end else if (state == DIV) begin
            counter <= counter + CW'(1);
            acc_hi  <= rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
            acc_lo  <= {acc_lo[WIDTH-2:0], rem_ge};
         end
      end
   end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: latency, sign handling, exceptions,
// abort/restart, back-to-back issue and asynchronous reset.
module tb_multdiv_unit;

   logic        clock;
   logic        reset;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] held_res;
   logic        held_exc;

   multdiv_unit #(.WIDTH(32)) dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      data_operandA = a;
      data_operandB = b;
   endtask

   task automatic clear_start();
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   // Edges E1..E32: busy high, no strobe, previous result held
   task automatic check_iters(input string tag);
      for (int i = 1; i <= 32; i++) begin
         tick();
         chk({tag, " rdy low"}, 32'(data_resultRDY), 32'd0);
         chk({tag, " busy"}, 32'(busy), 32'd1);
         chk({tag, " hold res"}, data_result, held_res);
      end
   endtask

   // Start sampled at E0, then full latency checks through E34
   task automatic run_op(input string tag, input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ee);
      set_start(m, d, a, b);
      tick();
      clear_start();
      chk({tag, " busy E0"}, 32'(busy), 32'd1);
      check_iters(tag);
      tick();
      chk({tag, " rdy E33"}, 32'(data_resultRDY), 32'd1);
      chk({tag, " busy E33"}, 32'(busy), 32'd0);
      chk({tag, " result"}, data_result, er);
      chk({tag, " exception"}, 32'(data_exception), 32'(ee));
      held_res = er;
      held_exc = ee;
      tick();
      chk({tag, " rdy E34"}, 32'(data_resultRDY), 32'd0);
      chk({tag, " held result"}, data_result, er);
      chk({tag, " held exc"}, 32'(data_exception), 32'(ee));
   endtask

   initial begin
      reset = 1'b0;
      clear_start();
      held_res = 32'd0;
      held_exc = 1'b0;
      repeat (2) tick();
      chk("reset result", data_result, 32'd0);
      chk("reset rdy", 32'(data_resultRDY), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      reset = 1'b1;

      // Idle after release
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle result", data_result, 32'd0);
         chk("idle exc", 32'(data_exception), 32'd0);
         chk("idle rdy", 32'(data_resultRDY), 32'd0);
         chk("idle busy", 32'(busy), 32'd0);
      end

      run_op("mul 7*-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
      run_op("mul max*2", 1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1);
      run_op("mul min*1", 1'b1, 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
      run_op("mul 2^16*2^16", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1);
      run_op("mul -5*-6", 1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd30, 1'b0);
      run_op("both 6,3", 1'b1, 1'b1, 32'd6, 32'd3, 32'd18, 1'b0);
      run_op("div -21/4", 1'b0, 1'b1, 32'hFFFF_FFEB, 32'd4, 32'hFFFF_FFFB, 1'b0);
      run_op("div 5/0", 1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1);
      run_op("div min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
      run_op("div 1000/-7", 1'b0, 1'b1, 32'd1000, 32'hFFFF_FFF9, 32'hFFFF_FF72, 1'b0);
      run_op("div 3/10", 1'b0, 1'b1, 32'd3, 32'd10, 32'd0, 1'b0);

      // Abort: MULT 6*7 at E0 restarted by DIV 100/7 at E10
      set_start(1'b1, 1'b0, 32'd6, 32'd7);
      tick();
      clear_start();
      repeat (9) begin
         tick();
         chk("abort pre rdy", 32'(data_resultRDY), 32'd0);
      end
      set_start(1'b0, 1'b1, 32'd100, 32'd7);
      tick();
      clear_start();
      check_iters("abort div");
      // E43: DIV completes while MULT 2*3 is issued in the strobe cycle
      set_start(1'b1, 1'b0, 32'd2, 32'd3);
      tick();
      clear_start();
      chk("abort rdy E43", 32'(data_resultRDY), 32'd1);
      chk("abort result", data_result, 32'd14);
      chk("abort exc", 32'(data_exception), 32'd0);
      held_res = 32'd14;
      check_iters("b2b mul");
      tick();
      chk("b2b rdy E76", 32'(data_resultRDY), 32'd1);
      chk("b2b result", data_result, 32'd6);
      tick();
      chk("b2b rdy drop", 32'(data_resultRDY), 32'd0);

      // Async reset in the middle of a divide
      set_start(1'b0, 1'b1, 32'd9, 32'd3);
      tick();
      clear_start();
      repeat (12) tick();
      #2 reset = 1'b0;
      #1;
      chk("mid rst result", data_result, 32'd0);
      chk("mid rst exc", 32'(data_exception), 32'd0);
      chk("mid rst rdy", 32'(data_resultRDY), 32'd0);
      chk("mid rst busy", 32'(busy), 32'd0);
      #2 reset = 1'b1;
      held_res = 32'd0;
      for (int i = 0; i < 40; i++) begin
         tick();
         chk("post rst no rdy", 32'(data_resultRDY), 32'd0);
         chk("post rst idle", 32'(busy), 32'd0);
      end
      run_op("mul 3*3", 1'b1, 1'b0, 32'd3, 32'd3, 32'd9, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed 32-bit multiply/divide unit that sits beside the execute-stage ALU in the 5-stage pipeline.
- Execute issues a one-cycle start pulse with operands. The unit asserts `busy` so hazard logic can stall D/X. It returns a registered result with a one-cycle ready strobe that the X/M latch captures.
- Multiply is a shift-add on magnitudes. Divide is restoring division on magnitudes. Sign is fixed up on completion.

Parameters:
- WIDTH, 32, operand and result width; iteration count equals WIDTH.

Ports:
- clock  input  1  master clock, rising edge
- reset  input  1  asynchronous, active-low reset
- ctrl_MULT  input  1  start multiply; sampled on rising edge
- ctrl_DIV  input  1  start divide; sampled on rising edge
- data_operandA  input  WIDTH  multiplicand / dividend; sampled with start
- data_operandB  input  WIDTH  multiplier / divisor; sampled with start
- data_result  output  WIDTH  product low word or quotient
- data_exception  output  1  overflow / divide-by-zero flag for data_result
- data_resultRDY  output  1  one-cycle strobe: result valid
- busy  output  1  high while an operation is in flight

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - Internal state: state=IDLE, counter=0, accumulators cleared.
  - Reset mid-operation aborts the operation with no RDY.
- States: IDLE, MULT, DIV, DONE.
- Start:
  - On an edge with ctrl_MULT=1 or ctrl_DIV=1 in any state, the unit latches |A|, |B|, result sign and op, clears counter to 0, and enters MULT or DIV.
  - If both start inputs are high, MULT wins.
  - A start while MULT/DIV is active aborts the current op and restarts. The old op never produces RDY.
- Iterate: one iteration per edge in MULT/DIV. counter increments 0..WIDTH-1. On the edge where counter==WIDTH-1 completes, the state goes to DONE.
- Latency: start sampled at edge E0, iterations on E1..E32, result registered at E33.
  - data_resultRDY=1 from E33 to E34 exactly; DONE lasts one cycle, then IDLE.
  - busy=1 from E0 up to E33, and 0 while RDY is high.
- Start during DONE (the RDY cycle) is accepted normally, giving back-to-back ops with 33-cycle spacing.
- Hold: data_result and data_exception hold their last value until the next completion. They are updated only at completion.
- Multiply:
  - 64-bit unsigned product of magnitudes, negated if the result sign is negative.
  - data_result = low 32 bits.
  - data_exception=1 iff the signed 64-bit product is outside [-2^31, 2^31-1]; i.e. the high 32 bits are not all copies of bit 31.
- Divide:
  - Quotient of magnitudes, negated if signs differ; truncates toward zero. The remainder is discarded.
  - Divisor 0: data_result=0, data_exception=1, same 33-cycle latency.
  - INT_MIN / -1: data_result=0x80000000, data_exception=1.
  - All other cases: data_exception=0.
- Operand inputs are ignored except on start edges; changes mid-operation have no effect.

Test Plan:
- Release reset, idle 5 cycles, no start -> result=0, exception=0, RDY=0, busy=0 throughout.
- MULT A=7, B=-3 at E0 -> busy high E0..E33; RDY high only E33-E34; result=0xFFFFFFEB (-21), exception=0; result held after RDY drops.
- MULT A=0x7FFFFFFF, B=2 -> result=0xFFFFFFFE, exception=1. MULT A=0x80000000, B=1 -> result=0x80000000, exception=0.
- DIV A=-21, B=4 -> result=0xFFFFFFFB (-5), exception=0. DIV A=5, B=0 -> result=0, exception=1 at E33. DIV A=0x80000000, B=-1 -> result=0x80000000, exception=1.
- MULT 6*7 at E0, then DIV 100/7 at E10 -> no RDY at E33; RDY at E43 with result=14; MULT 2*3 issued in the E43 RDY cycle -> RDY at E76 with result=6.
- DIV 9/3 started, reset pulsed low mid-cycle at iteration 12 (between edges) -> all outputs 0 immediately, no RDY afterwards; a new MULT 3*3 after release -> result=9 at E33.
